// File: rtl/gcd_sched_pkg.sv
// Shared types and widths for the GCD job scheduler.
// Exports: state_t (FSM states), OP_W, CYC_W, WDOG_W.
package gcd_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int OP_W   = 12;
    localparam int CYC_W  = 12;
    localparam int WDOG_W = 13;

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// Ports: req (in), ptr (in) -> gnt (one-hot or zero), gnt_idx (index of winner).
module gcd_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_idx
);

    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        // Walk the ring starting at ptr; the first valid one wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[IDW'(idx)]) begin
                found             = 1'b1;
                gnt[IDW'(idx)]    = 1'b1;
                gnt_idx           = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/gcd_job_scheduler.sv
// Shares one GCD core among NUM_REQ requesters with round-robin job arbitration,
//   operand latching, a per-job watchdog and a tagged response port.
// Ports: req_* (per-requester job in, req_ready out), rsp_* (tagged result out),
//   core_* (launch/operands out, done/results in), busy (job in flight).
module gcd_job_scheduler
    import gcd_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = $clog2(NUM_REQ),
    parameter int OPW     = 1279,
    parameter int RW      = 1284,
    parameter int TIMEOUT = 4200
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_op_code,
    input  logic [NUM_REQ-1:0]      req_ct,
    input  logic [NUM_REQ*OPW-1:0]  req_a,
    input  logic [NUM_REQ*OPW-1:0]  req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic                    rsp_err,
    output logic [RW-1:0]           rsp_bezout_a,
    output logic [RW-1:0]           rsp_bezout_b,
    output logic [CYC_W-1:0]        rsp_cycles,
    output logic                    core_clk_en,
    output logic                    core_start,
    output logic [OP_W-1:0]         core_op_code,
    output logic                    core_ct,
    output logic [OPW-1:0]          core_a,
    output logic [OPW-1:0]          core_b,
    input  logic                    core_done,
    input  logic [RW-1:0]           core_bezout_a,
    input  logic [RW-1:0]           core_bezout_b,
    input  logic [CYC_W-1:0]        core_cycles,
    output logic                    busy
);

    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
    localparam logic [IDW-1:0]    PTR_LAST  = IDW'(NUM_REQ - 1);

    state_t              state;
    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      job_id;
    logic [WDOG_W-1:0]   wdog;
    logic [NUM_REQ-1:0]  gnt;
    logic [IDW-1:0]      gnt_idx;
    logic                hs;

    gcd_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Gated by rst_n so nothing is offered while reset is held.
    assign req_ready = (state == S_IDLE && rst_n) ? gnt : '0;
    assign hs        = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            ptr          <= '0;
            job_id       <= '0;
            wdog         <= '0;
            core_start   <= 1'b0;
            core_clk_en  <= 1'b0;
            busy         <= 1'b0;
            core_op_code <= '0;
            core_ct      <= 1'b0;
            core_a       <= '0;
            core_b       <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_err      <= 1'b0;
            rsp_bezout_a <= '0;
            rsp_bezout_b <= '0;
            rsp_cycles   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (hs) begin
                        core_op_code <= req_op_code[int'(gnt_idx)*OP_W +: OP_W];
                        core_ct      <= req_ct[gnt_idx];
                        core_a       <= req_a[int'(gnt_idx)*OPW +: OPW];
                        core_b       <= req_b[int'(gnt_idx)*OPW +: OPW];
                        job_id       <= gnt_idx;
                        ptr          <= (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
                        core_start   <= 1'b1;
                        core_clk_en  <= 1'b1;
                        busy         <= 1'b1;
                        state        <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    core_start <= 1'b0;
                    wdog       <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    // done is checked first so it wins over a same-cycle expiry.
                    if (core_done) begin
                        rsp_err      <= 1'b0;
                        rsp_bezout_a <= core_bezout_a;
                        rsp_bezout_b <= core_bezout_b;
                        rsp_cycles   <= core_cycles;
                        rsp_id       <= job_id;
                        rsp_valid    <= 1'b1;
                        state        <= S_RESP;
                    end else if (wdog == WDOG_LAST) begin
                        rsp_err      <= 1'b1;
                        rsp_bezout_a <= '0;
                        rsp_bezout_b <= '0;
                        rsp_cycles   <= '0;
                        rsp_id       <= job_id;
                        rsp_valid    <= 1'b1;
                        state        <= S_RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        core_clk_en <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Directed self-checking bench for gcd_job_scheduler with a behavioural core model.
// Core model raises done a programmable number of cycles after start, or never.
module tb_gcd_job_scheduler;

    localparam int NR   = 2;
    localparam int IDW  = 1;
    localparam int OPW  = 1279;
    localparam int RW   = 1284;
    localparam int TO   = 4200;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*12-1:0]  req_op_code = '0;
    logic [NR-1:0]     req_ct = '0;
    logic [NR*OPW-1:0] req_a = '0;
    logic [NR*OPW-1:0] req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_err;
    logic [RW-1:0]     rsp_bezout_a;
    logic [RW-1:0]     rsp_bezout_b;
    logic [11:0]       rsp_cycles;
    logic              core_clk_en;
    logic              core_start;
    logic [11:0]       core_op_code;
    logic              core_ct;
    logic [OPW-1:0]    core_a;
    logic [OPW-1:0]    core_b;
    logic              core_done;
    logic [RW-1:0]     core_bezout_a;
    logic [RW-1:0]     core_bezout_b;
    logic [11:0]       core_cycles;
    logic              busy;

    gcd_job_scheduler #(
        .NUM_REQ(NR), .IDW(IDW), .OPW(OPW), .RW(RW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_code(req_op_code), .req_ct(req_ct),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_bezout_a(rsp_bezout_a), .rsp_bezout_b(rsp_bezout_b),
        .rsp_cycles(rsp_cycles),
        .core_clk_en(core_clk_en), .core_start(core_start),
        .core_op_code(core_op_code), .core_ct(core_ct),
        .core_a(core_a), .core_b(core_b),
        .core_done(core_done),
        .core_bezout_a(core_bezout_a), .core_bezout_b(core_bezout_b),
        .core_cycles(core_cycles),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Core model
    logic          m_hang = 1'b0;
    int            m_delay = 5;
    logic [RW-1:0] m_ba = '0;
    logic [RW-1:0] m_bb = '0;
    logic [11:0]   m_cyc = '0;
    logic          m_run;
    int            m_cnt;

    assign core_bezout_a = m_ba;
    assign core_bezout_b = m_bb;
    assign core_cycles   = m_cyc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_done <= 1'b0;
            m_run     <= 1'b0;
            m_cnt     <= 0;
        end else if (core_start) begin
            core_done <= 1'b0;
            m_run     <= 1'b1;
            m_cnt     <= 0;
        end else if (m_run && !m_hang) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_delay) begin
                core_done <= 1'b1;
                m_run     <= 1'b0;
            end
        end
    end

    int n_start = 0;
    always @(negedge clk) if (core_start) n_start++;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [RW-1:0] obs,
                         input logic [RW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Captured response of the last do_job
    logic          got;
    int            waitc;
    logic [IDW-1:0] r_id;
    logic          r_err;
    logic [RW-1:0] r_ba, r_bb;
    logic [11:0]   r_cyc;
    logic [OPW-1:0] r_ca, r_cb;

    // Runs one job from requester id; entered and left at a negedge.
    // waitc counts samples between the launch cycle and rsp_valid.
    task automatic do_job(input int id, input logic [OPW-1:0] a,
                          input logic [OPW-1:0] b, input int hold);
        logic hs;
        int   bad;
        hs = 1'b0;
        got = 1'b0;
        waitc = 0;
        req_a[id*OPW +: OPW] = a;
        req_b[id*OPW +: OPW] = b;
        req_op_code[id*12 +: 12] = 12'h0A5;
        req_ct[id] = 1'b1;
        req_valid[id] = 1'b1;
        rsp_ready = (hold == 0);
        for (int i = 0; i < 20 && !hs; i++) begin
            #1;
            if (req_ready[id]) hs = 1'b1;
            @(negedge clk);
        end
        check("accept", hs, 1);
        req_valid[id] = 1'b0;
        check("launch_start", core_start, 1);
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
            else waitc++;
        end
        check("rsp_seen", got, 1);
        r_id  = rsp_id;
        r_err = rsp_err;
        r_ba  = rsp_bezout_a;
        r_bb  = rsp_bezout_b;
        r_cyc = rsp_cycles;
        r_ca  = core_a;
        r_cb  = core_b;
        if (hold > 0) begin
            bad = 0;
            req_valid = '1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_bezout_a !== r_ba ||
                    rsp_bezout_b !== r_bb || rsp_cycles !== r_cyc ||
                    rsp_id !== r_id || rsp_err !== r_err ||
                    core_a !== r_ca || core_b !== r_cb) bad++;
                if (req_ready !== '0 || busy !== 1'b1) bad++;
            end
            check("hold_stable", bad, 0);
            req_valid = '0;
            rsp_ready = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        int ns;
        int ng, nr, drop, g, bad;
        int cnt[NR];

        // Reset state
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_start", core_start, 0);
        check("rst_clk_en", core_clk_en, 0);
        check("rst_busy", busy, 0);
        check("rst_core_a", core_a, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Two requesters contending, 4 jobs each
        m_hang = 1'b0; m_delay = 5;
        req_a = '0; req_b = '0;
        req_valid = 2'b11; rsp_ready = 1'b1;
        cnt[0] = 4; cnt[1] = 4; ng = 0; nr = 0; drop = -1;
        for (int t = 0; t < 2000 && (ng < 8 || nr < 8); t++) begin
            if (drop >= 0) begin req_valid[drop] = 1'b0; drop = -1; end
            #1;
            if (rsp_valid) begin
                check("rr_rsp_id", rsp_id, nr % 2);
                nr++;
            end
            if (|(req_valid & req_ready)) begin
                g = req_ready[1] ? 1 : 0;
                check("rr_grant", g, ng % 2);
                cnt[g]--;
                if (cnt[g] == 0) drop = g;
                ng++;
            end
            @(negedge clk);
        end
        check("rr_grants", ng, 8);
        check("rr_rsps", nr, 8);
        req_valid = '0;
        @(negedge clk);

        // Single job, long core run
        m_delay = 4096;
        m_ba = RW'(20); m_bb = RW'(4); m_cyc = 12'hFFF;
        ns = n_start;
        do_job(0, OPW'(12), OPW'(8), 0);
        check("t1_starts", n_start - ns, 1);
        check("t1_id", r_id, 0);
        check("t1_err", r_err, 0);
        check("t1_ba", r_ba, 20);
        check("t1_bb", r_bb, 4);
        check("t1_cyc", r_cyc, 12'hFFF);
        check("t1_core_a", r_ca, 12);
        check("t1_core_b", r_cb, 8);
        check("t1_idle_busy", busy, 0);

        // Response back-pressure for 50 cycles
        m_delay = 7;
        m_ba = RW'(33); m_bb = RW'(77); m_cyc = 12'h123;
        do_job(1, OPW'(100), OPW'(35), 50);
        check("t3_id", r_id, 1);
        check("t3_ba", r_ba, 33);
        check("t3_cyc", r_cyc, 12'h123);
        check("t3_released", rsp_valid, 0);

        // Hung core: watchdog
        m_hang = 1'b1;
        m_ba = RW'(999); m_bb = RW'(555); m_cyc = 12'h777;
        do_job(0, OPW'(5), OPW'(3), 0);
        check("t4_wait_cycles", waitc, TO);
        check("t4_err", r_err, 1);
        check("t4_ba", r_ba, 0);
        check("t4_bb", r_bb, 0);
        check("t4_cyc", r_cyc, 0);
        m_hang = 1'b0; m_delay = 10;
        m_ba = RW'(6); m_bb = RW'(2); m_cyc = 12'h00A;
        do_job(1, OPW'(9), OPW'(6), 0);
        check("t4_next_err", r_err, 0);
        check("t4_next_ba", r_ba, 6);
        check("t4_next_id", r_id, 1);

        // done coinciding with watchdog expiry
        m_delay = TO - 1;
        m_ba = RW'(41); m_bb = RW'(17); m_cyc = 12'hABC;
        do_job(0, OPW'(21), OPW'(14), 0);
        check("t6_wait_cycles", waitc, TO);
        check("t6_err", r_err, 0);
        check("t6_ba", r_ba, 41);
        check("t6_bb", r_bb, 17);
        check("t6_cyc", r_cyc, 12'hABC);

        // Async reset mid-WAIT; req0 was last granted so ptr is 1 here
        m_hang = 1'b1;
        req_valid[0] = 1'b1;
        g = 0;
        for (int i = 0; i < 20 && g == 0; i++) begin
            #1;
            if (req_ready[0]) g = 1;
            @(negedge clk);
        end
        check("t5_accept", g, 1);
        req_valid = '0;
        repeat (20) @(negedge clk);
        check("t5_in_wait_busy", busy, 1);
        req_valid = 2'b11;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_clk_en", core_clk_en, 0);
        check("t5_rst_start", core_start, 0);
        check("t5_rst_ready", req_ready, 0);
        check("t5_rst_rsp", rsp_valid, 0);
        repeat (3) @(negedge clk);
        m_hang = 1'b0; m_delay = 4;
        rst_n = 1'b1;
        #1;
        check("t5_ptr0_grant", req_ready, 2'b01);
        req_valid = '0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        check("t5_no_rsp", bad, 0);
        m_ba = RW'(8); m_bb = RW'(1); m_cyc = 12'h004;
        do_job(0, OPW'(16), OPW'(24), 0);
        check("t5_new_id", r_id, 0);
        check("t5_new_ba", r_ba, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
